uart_tx_scheduler: RTL

Round-robin scheduler that shares the single 32-bit `uart_tx` word transmitter among `N_REQ` requesters, e.g. the sample dumper, the trigger-status reporter and the host-command responder. It arbitrates among pending requests and latches the winner's word. It then sequences the transmitter's `fetch`/`transmit` strobes, tracks `busy` until the 4-byte frame completes, and acknowledges the requester. It sits between the capture logic and `uart_tx`, and is the only driver of the transmitter's control inputs.

---
 rtl/uart_sched_pkg.sv | 17 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 42 ++++
 rtl/uart_tx_scheduler.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared constants and state encoding for the uart_tx word scheduler
package uart_sched_pkg;

    localparam int WORD_W               = 32;
    localparam int DEFAULT_BUSY_TIMEOUT = 15;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LATCH     = 3'd1,
        ST_FETCH     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_ACK       = 3'd6
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rtl/uart_tx_scheduler_rr_arbiter.sv - combinational round-robin first-set scan
//
// Ports:
//   req       : pending request vector
//   rr        : index where the scan starts (highest priority)
//   gnt_valid : at least one request is pending
//   gnt_idx   : first set request found scanning rr, rr+1, ... modulo N_REQ
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam logic [IDX_W:0] N_L = (IDX_W+1)'(N_REQ);

    // Doubling the vector turns the wrap-around scan into a plain shift:
    // bit i of the shifted vector is request (rr + i) mod N_REQ.
    logic [2*N_REQ-1:0] rotated;
    logic [IDX_W:0]     sum;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        rotated   = {req, req} >> rr;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_valid && rotated[i]) begin
                gnt_valid = 1'b1;
                sum       = {1'b0, rr} + (IDX_W+1)'(i);
                if (sum >= N_L) begin
                    sum = sum - N_L;
                end
                gnt_idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin scheduler sharing one uart_tx word transmitter
//
// Ports:
//   i_clk, _rst   : clock, synchronous active-low reset
//   req, req_data : per-requester level request and 32-bit word (word i at [32i+31:32i])
//   ack           : one-cycle pulse on the granted bit when its word is done or aborted
//   err_timeout   : one-cycle pulse with ack when tx_busy never rose
//   active        : high from LATCH through ACK
//   grant_idx     : current or last granted requester
//   tx_data, tx_fetch, tx_transmit : word and strobes to uart_tx (all registered)
//   tx_busy       : busy from uart_tx
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int IDX_W        = 2,
    parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    _rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WORD_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    err_timeout,
    output logic                    active,
    output logic [IDX_W-1:0]        grant_idx,
    output logic [WORD_W-1:0]       tx_data,
    output logic                    tx_fetch,
    output logic                    tx_transmit,
    input  logic                    tx_busy
);

    localparam logic [7:0]       TIMEOUT_CNT = 8'(BUSY_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REQ - 1);

    sched_state_t state, state_nxt;

    logic [IDX_W-1:0]  rr, rr_d;
    logic [7:0]        busy_cnt, busy_cnt_d;
    logic              gnt_valid;
    logic [IDX_W-1:0]  gnt_idx;
    logic [WORD_W-1:0] win_word;
    logic [N_REQ-1:0]  grant_onehot;
    logic              busy_expired;

    logic [N_REQ-1:0]  ack_d;
    logic              err_timeout_d;
    logic              active_d;
    logic [IDX_W-1:0]  grant_idx_d;
    logic [WORD_W-1:0] tx_data_d;
    logic              tx_fetch_d;
    logic              tx_transmit_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .rr        (rr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_comb begin
        win_word     = '0;
        grant_onehot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                win_word = req_data[i*WORD_W +: WORD_W];
            end
            grant_onehot[i] = (grant_idx == IDX_W'(i));
        end
    end

    // Busy has priority over the timeout on the same edge.
    assign busy_expired = !tx_busy && (busy_cnt == TIMEOUT_CNT);

    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (gnt_valid) state_nxt = ST_LATCH;
            ST_LATCH:     state_nxt = ST_FETCH;
            ST_FETCH:     state_nxt = ST_START;
            ST_START:     state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end else if (busy_expired) begin
                    state_nxt = ST_ACK;
                end
            end
            // Frame length depends on baud, so no timeout here.
            ST_WAIT_DONE: if (!tx_busy) state_nxt = ST_ACK;
            ST_ACK:       state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; every output leaves a flop.
    always_comb begin
        tx_data_d     = tx_data;
        grant_idx_d   = grant_idx;
        active_d      = active;
        rr_d          = rr;
        busy_cnt_d    = busy_cnt;
        tx_fetch_d    = 1'b0;
        tx_transmit_d = 1'b0;
        ack_d         = '0;
        err_timeout_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_valid) begin
                    tx_data_d   = win_word;
                    grant_idx_d = gnt_idx;
                    active_d    = 1'b1;
                end
            end
            ST_LATCH: tx_fetch_d    = 1'b1;
            ST_FETCH: tx_transmit_d = 1'b1;
            ST_START: busy_cnt_d    = '0;
            ST_WAIT_BUSY: begin
                if (!tx_busy) begin
                    if (busy_expired) begin
                        ack_d         = grant_onehot;
                        err_timeout_d = 1'b1;
                    end else if (busy_cnt != 8'hFF) begin
                        busy_cnt_d = busy_cnt + 8'd1;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    ack_d = grant_onehot;
                end
            end
            ST_ACK: begin
                active_d = 1'b0;
                rr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!_rst) begin
            tx_data     <= '0;
            tx_fetch    <= 1'b0;
            tx_transmit <= 1'b0;
            ack         <= '0;
            err_timeout <= 1'b0;
            active      <= 1'b0;
            grant_idx   <= '0;
            rr          <= '0;
            busy_cnt    <= '0;
        end else begin
            tx_data     <= tx_data_d;
            tx_fetch    <= tx_fetch_d;
            tx_transmit <= tx_transmit_d;
            ack         <= ack_d;
            err_timeout <= err_timeout_d;
            active      <= active_d;
            grant_idx   <= grant_idx_d;
            rr          <= rr_d;
            busy_cnt    <= busy_cnt_d;
        end
    end

endmodule
